// File: rtl/push_button_event_pkg.sv
// push_button_event_pkg: state encoding and default parameters for the push-button event decoder
package push_button_event_pkg;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESSED   = 2'd1;
    localparam logic [1:0] LONG_HELD = 2'd2;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 25_000_000;
    localparam int DEFAULT_REPEAT_CYCLES     = 5_000_000;
    localparam int DEFAULT_REPEAT_ENABLE     = 1;
    localparam int DEFAULT_COUNTER_WIDTH     = 26;
endpackage

// File: rtl/button_hold_timer.sv
// button_hold_timer: hold-duration counter with clear, enable and terminal-value compare
module button_hold_timer
    import push_button_event_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] terminal_value,
    output logic                     terminal
);
    logic [COUNTER_WIDTH-1:0] count;
    // clear wins over enable so a terminal hit restarts the next interval from zero
    always_ff @(posedge clock) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + COUNTER_WIDTH'(1);
    end
    assign terminal = (count == terminal_value);
endmodule

// File: rtl/push_button_event_decoder.sv
// push_button_event_decoder: turns a debounced button level into press/release/long/repeat events
module push_button_event_decoder
    import push_button_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES,
    parameter int REPEAT_ENABLE     = DEFAULT_REPEAT_ENABLE,
    parameter int COUNTER_WIDTH     = DEFAULT_COUNTER_WIDTH
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_button,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);
    logic [1:0] state, next_state;
    logic btn_q, terminal, timer_clear, timer_enable;
    logic press_d, release_d, long_d, repeat_d;
    logic [COUNTER_WIDTH-1:0] terminal_value;

    assign terminal_value = (state == PRESSED) ? COUNTER_WIDTH'(LONG_PRESS_CYCLES - 1)
                                               : COUNTER_WIDTH'(REPEAT_CYCLES - 1);

    button_hold_timer #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_timer (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear         (timer_clear),
        .enable        (timer_enable),
        .terminal_value(terminal_value),
        .terminal      (terminal)
    );

    // next-state and event decode; release is tested first so it beats a terminal count
    always_comb begin
        next_state   = state;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;
        repeat_d     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_q) begin
                    next_state  = PRESSED;
                    timer_clear = 1'b1;
                    press_d     = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_q) begin
                    next_state = IDLE;
                    release_d  = 1'b1;
                end else if (terminal) begin
                    next_state  = LONG_HELD;
                    timer_clear = 1'b1;
                    long_d      = 1'b1;
                end else
                    timer_enable = 1'b1;
            end
            LONG_HELD: begin
                if (!btn_q) begin
                    next_state = IDLE;
                    release_d  = 1'b1;
                end else if (terminal) begin
                    timer_clear = 1'b1;
                    repeat_d    = (REPEAT_ENABLE != 0);
                end else
                    timer_enable = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // input register, state, registered event pulses and press counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            btn_q            <= 1'b0;
            state            <= IDLE;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            repeat_pulse     <= 1'b0;
            held             <= 1'b0;
            press_count      <= 8'd0;
        end else begin
            btn_q            <= push_button;
            state            <= next_state;
            press_pulse      <= press_d;
            release_pulse    <= release_d;
            long_press_pulse <= long_d;
            repeat_pulse     <= repeat_d;
            held             <= (next_state != IDLE);
            press_count      <= press_count + {7'd0, press_d};
        end
    end
endmodule

// File: tb/tb_push_button_event_decoder.sv
// tb_push_button_event_decoder: directed bench with a run-length reference model and literal checks
module tb_push_button_event_decoder;
    localparam int L = 8;
    localparam int R = 4;

    logic clock = 1'b0;
    logic reset_n, push_button;
    logic a_press, a_rel, a_long, a_rep, a_held;
    logic b_press, b_rel, b_long, b_rep, b_held;
    logic [7:0] a_cnt, b_cnt;

    always #5 clock = ~clock;

    push_button_event_decoder #(.LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_ENABLE(1), .COUNTER_WIDTH(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .push_button(push_button),
        .press_pulse(a_press), .release_pulse(a_rel), .long_press_pulse(a_long),
        .repeat_pulse(a_rep), .held(a_held), .press_count(a_cnt));

    push_button_event_decoder #(.LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_ENABLE(0), .COUNTER_WIDTH(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .push_button(push_button),
        .press_pulse(b_press), .release_pulse(b_rel), .long_press_pulse(b_long),
        .repeat_pulse(b_rep), .held(b_held), .press_count(b_cnt));

    int tests = 0, fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: the length of the current run of sampled-high cycles decides every event
    bit m_valid = 0, m_bq = 0;
    int m_run = 0, e_cnt = 0;
    bit e_press, e_rel, e_long, e_rep, e_held;
    int cyc = 0;

    always @(posedge clock) begin
        cyc++;
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        if (!reset_n) begin
            m_bq = 0; m_run = 0; e_held = 0; e_cnt = 0;
        end else begin
            if (m_bq) begin
                m_run++;
                e_press = (m_run == 1);
                e_long  = (m_run == L + 1);
                e_rep   = (m_run > L + 1) && ((m_run - L - 1) % R == 0);
                e_held  = 1;
            end else begin
                e_rel  = (m_run > 0);
                m_run  = 0;
                e_held = 0;
            end
            if (e_press) e_cnt = (e_cnt + 1) % 256;
            m_bq = push_button;
        end
        m_valid = 1;
    end

    int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0, n_rep_b = 0, n_held = 0;
    int t_press = -1, t_rel = -1, t_long = -1, t_rep1 = -1;

    always @(negedge clock) begin
        if (m_valid) begin
            chk("a_press", a_press, e_press);
            chk("a_release", a_rel, e_rel);
            chk("a_long", a_long, e_long);
            chk("a_repeat", a_rep, e_rep);
            chk("a_held", a_held, e_held);
            chk("a_count", a_cnt, e_cnt);
            chk("b_press", b_press, e_press);
            chk("b_release", b_rel, e_rel);
            chk("b_long", b_long, e_long);
            chk("b_repeat", b_rep, 0);
            chk("b_held", b_held, e_held);
            chk("b_count", b_cnt, e_cnt);
            if (a_press) begin n_press++; t_press = cyc; end
            if (a_rel) begin n_rel++; t_rel = cyc; end
            if (a_long) begin n_long++; t_long = cyc; end
            if (a_rep) begin n_rep++; if (t_rep1 < t_long) t_rep1 = cyc; end
            if (b_rep) n_rep_b++;
            if (a_held) n_held++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    int press0, rel0;

    initial begin
        reset_n = 1'b0;
        push_button = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(20);
        #1;
        chk("idle_count", a_cnt, 0);
        chk("idle_presses", n_press, 0);
        push_button = 1'b1;
        step(3);
        push_button = 1'b0;
        step(6);
        #1;
        chk("short_presses", n_press, 1);
        chk("short_count", a_cnt, 1);
        chk("short_held_cycles", n_held, 3);
        chk("short_release_gap", t_rel - t_press, 3);
        chk("short_no_long", n_long, 0);
        push_button = 1'b1;
        step(30);
        push_button = 1'b0;
        step(6);
        #1;
        chk("long_gap", t_long - t_press, 8);
        chk("first_repeat_gap", t_rep1 - t_long, 4);
        chk("repeat_count", n_rep, 5);
        chk("repeat_disabled_count", n_rep_b, 0);
        chk("long_releases", n_rel, 2);
        push_button = 1'b1;
        step(8);
        push_button = 1'b0;
        step(6);
        #1;
        chk("terminal_no_long", n_long, 1);
        chk("terminal_release", n_rel, 3);
        chk("terminal_idle", a_held, 0);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        for (int i = 0; i < 255; i++) begin
            push_button = 1'b1;
            step(2);
            push_button = 1'b0;
            step(2);
        end
        #1;
        chk("count_255", a_cnt, 255);
        push_button = 1'b1;
        step(2);
        push_button = 1'b0;
        step(2);
        #1;
        chk("count_wrap", a_cnt, 0);
        push_button = 1'b1;
        step(12);
        press0 = n_press;
        rel0 = n_rel;
        reset_n = 1'b0;
        step(3);
        #1;
        chk("reset_held", a_held, 0);
        chk("reset_count", a_cnt, 0);
        reset_n = 1'b1;
        step(1);
        #1;
        chk("reset_no_early_press", n_press - press0, 0);
        step(1);
        #1;
        chk("reset_new_press", n_press - press0, 1);
        chk("reset_no_release", n_rel - rel0, 0);
        push_button = 1'b0;
        step(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
